// File: rtl/link_pkg.sv
// Shared types and dual-rail encoding helpers for the link transmitter.
package link_pkg;

    typedef enum logic {ENC_TP, ENC_FP} enc_e;

    typedef struct packed {
        logic rail1;
        logic rail0;
    } rail_pair_t;

    // Widest payload the encoder supports; callers truncate to their own width.
    localparam int MAX_W = 64;

    typedef rail_pair_t [MAX_W-1:0] rail_vec_t;

    localparam rail_vec_t SPACER = '0;

    // Return-to-zero codeword: exactly one rail high per bit.
    function automatic rail_vec_t encode_fp(input logic [MAX_W-1:0] word);
        rail_vec_t r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i].rail1 = word[i];
            r[i].rail0 = ~word[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/link_tx_sync_ack_sync.sv
// Multi-flop synchronizer bringing the asynchronous link acknowledge into clk.
module ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ack_in,
    output logic ack_s
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ack_in};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/link_tx_sync.sv
// Clocked source of a dual-rail self-timed link, two-phase or four-phase handshake.
// Optional watchdog on the handshake waits: define LINK_TX_SYNC_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | ready for a word, no token outstanding
// WAIT_ACK | token on the link, waiting for the acknowledge
// RTZ      | (FP) spacer driven for one cycle
// WAIT_RTZ | (FP) waiting for the acknowledge to return to zero
module link_tx_sync
    import link_pkg::*;
#(
    parameter int W           = 8,
    parameter     ENC         = "TP",
    parameter int SYNC_STAGES = 2,
    parameter int TO_CYCLES   = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [2*W-1:0] out_data,
    input  logic           out_ack,
    output logic           busy
`ifdef LINK_TX_SYNC_TIMEOUT_EN
    ,
    output logic           timeout_err
`endif
);

    localparam enc_e ENC_MODE = (ENC == "FP") ? ENC_FP : ENC_TP;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_ACK = 2'd1;
    localparam logic [1:0] S_RTZ      = 2'd2;
    localparam logic [1:0] S_WAIT_RTZ = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [2*W-1:0] out_data_q, out_data_d;
    logic           phase_q, phase_d;
    logic           in_ready_q, in_ready_d;
    logic           ack_s;
    logic           accept;
    logic [MAX_W-1:0] word_ext;
    logic [2*W-1:0] enc_w;

    ack_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .ack_in (out_ack),
        .ack_s  (ack_s)
    );

    // The FP codeword doubles as the TP toggle mask: rail1 flips for a 1, rail0 for a 0.
    always_comb begin
        word_ext = MAX_W'(in_data);
        enc_w    = (2*W)'(encode_fp(word_ext));
    end

    assign accept = in_valid & in_ready_q;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        phase_d    = phase_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT_ACK;
                    phase_d = ~phase_q;
                    if (ENC_MODE == ENC_TP) begin
                        out_data_d = out_data_q ^ enc_w;
                    end else begin
                        out_data_d = enc_w;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (ENC_MODE == ENC_TP) begin
                    if (ack_s == phase_q) begin
                        state_d = S_IDLE;
                    end
                end else if (ack_s) begin
                    state_d    = S_RTZ;
                    out_data_d = (2*W)'(SPACER);
                end
            end
            S_RTZ: begin
                state_d = S_WAIT_RTZ;
            end
            S_WAIT_RTZ: begin
                if (!ack_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Registered so that ready stays low on the edge that releases reset.
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            out_data_q <= '0;
            phase_q    <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            phase_q    <= phase_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_data = out_data_q;
    assign in_ready = in_ready_q;
    assign busy     = (state_q != S_IDLE);

`ifdef LINK_TX_SYNC_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_err_q, timeout_err_d;

    // Saturating dwell counter; the FSM keeps waiting after the flag sets.
    always_comb begin
        to_cnt_d      = '0;
        timeout_err_d = timeout_err_q;
        if ((state_d == state_q) &&
            ((state_q == S_WAIT_ACK) || (state_q == S_WAIT_RTZ))) begin
            if (to_cnt_q != TO_W'(TO_CYCLES)) begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end else begin
                to_cnt_d = to_cnt_q;
            end
            if (to_cnt_d == TO_W'(TO_CYCLES)) begin
                timeout_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_link_tx_sync.sv
// Directed bench: one FP and one TP instance (W=4) driven from a shared clock and reset.
module tb_link_tx_sync;

    logic       clk;
    logic       rst_n;

    logic [3:0] fp_data, tp_data;
    logic       fp_valid, tp_valid;
    logic       fp_ready, tp_ready;
    logic [7:0] fp_out, tp_out;
    logic       fp_ack, tp_ack;
    logic       fp_busy, tp_busy;
`ifdef LINK_TX_SYNC_TIMEOUT_EN
    logic       fp_terr, tp_terr;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    link_tx_sync #(.W(4), .ENC("FP"), .SYNC_STAGES(2), .TO_CYCLES(16)) u_fp (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (fp_data),
        .in_valid    (fp_valid),
        .in_ready    (fp_ready),
        .out_data    (fp_out),
        .out_ack     (fp_ack),
        .busy        (fp_busy)
`ifdef LINK_TX_SYNC_TIMEOUT_EN
        ,
        .timeout_err (fp_terr)
`endif
    );

    link_tx_sync #(.W(4), .ENC("TP"), .SYNC_STAGES(2), .TO_CYCLES(16)) u_tp (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (tp_data),
        .in_valid    (tp_valid),
        .in_ready    (tp_ready),
        .out_data    (tp_out),
        .out_ack     (tp_ack),
        .busy        (tp_busy)
`ifdef LINK_TX_SYNC_TIMEOUT_EN
        ,
        .timeout_err (tp_terr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance n rising edges; inputs driven and outputs sampled 1ns after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Back-pressure words and the TP link values they leave behind, starting from 8'hFF.
    logic [3:0] bp_word [3] = '{4'h3, 4'h5, 4'hC};
    logic [7:0] bp_exp  [3] = '{8'hA5, 8'hC3, 8'h66};

    initial begin
        rst_n    = 1'b0;
        fp_data  = '0; fp_valid = 1'b0; fp_ack = 1'b0;
        tp_data  = '0; tp_valid = 1'b0; tp_ack = 1'b0;
        tick(2);

        check("rst_fp_out",   fp_out,   8'h00);
        check("rst_fp_ready", fp_ready, 1'b0);
        check("rst_fp_busy",  fp_busy,  1'b0);
        check("rst_tp_out",   tp_out,   8'h00);
        check("rst_tp_ready", tp_ready, 1'b0);
`ifdef LINK_TX_SYNC_TIMEOUT_EN
        check("rst_fp_terr",  fp_terr,  1'b0);
`endif
        rst_n = 1'b1;
        tick(1);
        check("rel_fp_ready", fp_ready, 1'b1);
        check("rel_tp_ready", tp_ready, 1'b1);

        // FP word 1010 and the full four-phase handshake timing
        fp_data = 4'b1010; fp_valid = 1'b1;
        tick(1);
        check("fp_word_out",   fp_out,   8'b1001_1001);
        check("fp_word_busy",  fp_busy,  1'b1);
        check("fp_word_ready", fp_ready, 1'b0);
        fp_valid = 1'b0;
        fp_ack   = 1'b1;
        tick(2);
        check("fp_hold_out",   fp_out,   8'b1001_1001);
        tick(1);
        check("fp_rtz_out",    fp_out,   8'h00);
        tick(2);
        fp_ack = 1'b0;
        tick(2);
        check("fp_wrtz_ready", fp_ready, 1'b0);
        tick(1);
        check("fp_idle_ready", fp_ready, 1'b1);
        check("fp_idle_busy",  fp_busy,  1'b0);

        // Spurious ack pulse while idle
        fp_ack = 1'b1;
        tick(1);
        fp_ack = 1'b0;
        tick(4);
        check("fp_spur_out",   fp_out,   8'h00);
        check("fp_spur_ready", fp_ready, 1'b1);
        check("fp_spur_busy",  fp_busy,  1'b0);

        // Ack held high through WAIT_RTZ: FSM must wait for it to fall
        fp_data = 4'b0110; fp_valid = 1'b1;
        tick(1);
        fp_valid = 1'b0;
        check("fp_w2_out",  fp_out, 8'b0110_1001);
        fp_ack = 1'b1;
        tick(3);
        check("fp_w2_rtz",  fp_out, 8'h00);
        tick(6);
        check("fp_w2_hold_busy",  fp_busy,  1'b1);
        check("fp_w2_hold_ready", fp_ready, 1'b0);
        check("fp_w2_hold_out",   fp_out,   8'h00);
        fp_ack = 1'b0;
        tick(2);
        check("fp_w2_pre_busy", fp_busy, 1'b1);
        tick(1);
        check("fp_w2_ready", fp_ready, 1'b1);
        check("fp_w2_busy",  fp_busy,  1'b0);

        // TP: F then 0 from reset
        tp_data = 4'hF; tp_valid = 1'b1;
        tick(1);
        tp_valid = 1'b0;
        check("tp_f_out",  tp_out,  8'b1010_1010);
        check("tp_f_busy", tp_busy, 1'b1);
        tp_ack = 1'b1;
        tick(2);
        check("tp_f_wait_busy", tp_busy, 1'b1);
        tick(1);
        check("tp_f_done_busy",  tp_busy,  1'b0);
        check("tp_f_done_ready", tp_ready, 1'b1);
        tp_data = 4'h0; tp_valid = 1'b1;
        tick(1);
        tp_valid = 1'b0;
        check("tp_0_out",  tp_out,  8'b1111_1111);
        check("tp_0_busy", tp_busy, 1'b1);
        tp_ack = 1'b0;
        tick(3);
        check("tp_0_done_busy", tp_busy, 1'b0);

        // Back-pressure: valid held high, each ack delayed 20 cycles
        for (int k = 0; k < 3; k++) begin
            int cnt;
            tp_data  = bp_word[k];
            tp_valid = 1'b1;
            check("bp_ready_pre", tp_ready, 1'b1);
            tick(1);
            check("bp_out", tp_out, bp_exp[k]);
            if (k < 2) tp_data = bp_word[k+1];
            else       tp_valid = 1'b0;
            for (int c = 0; c < 20; c++) begin
                tick(1);
                check("bp_ready_low", tp_ready, 1'b0);
                check("bp_out_hold",  tp_out,   bp_exp[k]);
            end
            tp_ack = ~tp_ack;
            cnt = 0;
            while (!tp_ready && cnt < 10) begin
                tick(1);
                cnt++;
            end
            check("bp_ack_latency", cnt, 3);
        end

        // One more TP word (1001): 66 ^ 96 = F0, ack back to 0
        tp_data = 4'h9; tp_valid = 1'b1;
        tick(1);
        tp_valid = 1'b0;
        check("tp_9_out", tp_out, 8'hF0);
        tp_ack = 1'b0;
        tick(3);
        check("tp_9_busy", tp_busy, 1'b0);

        // 0110: F0 ^ 69 = 99, phase now 1; reset mid-token
        tp_data = 4'h6; tp_valid = 1'b1;
        tick(1);
        tp_valid = 1'b0;
        check("tp_6_out", tp_out, 8'h99);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_out",   tp_out,   8'h00);
        check("mid_rst_ready", tp_ready, 1'b0);
        check("mid_rst_busy",  tp_busy,  1'b0);
        rst_n = 1'b1;
        tick(1);
        check("mid_rel_ready", tp_ready, 1'b1);
        tp_data = 4'hF; tp_valid = 1'b1;
        tick(1);
        tp_valid = 1'b0;
        check("post_rst_out", tp_out, 8'b1010_1010);
        tick(5);
        check("post_rst_wait_busy", tp_busy, 1'b1);
        tp_ack = 1'b1;
        tick(3);
        check("post_rst_done_busy", tp_busy, 1'b0);

`ifdef LINK_TX_SYNC_TIMEOUT_EN
        // Watchdog: never ack, flag on the 16th WAIT_ACK cycle, sticky after late ack
        fp_data = 4'h1; fp_valid = 1'b1;
        tick(1);
        fp_valid = 1'b0;
        check("to_start", fp_terr, 1'b0);
        tick(15);
        check("to_pre",   fp_terr, 1'b0);
        tick(1);
        check("to_set",   fp_terr, 1'b1);
        check("to_busy",  fp_busy, 1'b1);
        fp_ack = 1'b1;
        tick(3);
        check("to_rtz_out", fp_out, 8'h00);
        fp_ack = 1'b0;
        tick(4);
        check("to_idle_ready", fp_ready, 1'b1);
        check("to_sticky",     fp_terr,  1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
